// File: rtl/radio_spi_scheduler_pkg.sv
// Shared definitions for the radio SPI scheduler: FSM states, table limits,
// byte-handshake constants and the write-address byte helper.
package radio_spi_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_POR_WAIT,
    ST_CS_SETUP,
    ST_SEND_ADDR,
    ST_WAIT_ADDR,
    ST_SEND_DATA,
    ST_WAIT_DATA,
    ST_CS_HOLD,
    ST_NEXT,
    ST_RECOVER,
    ST_IDLE
  } state_t;

  localparam int unsigned INIT_LEN_MAX  = 16;
  localparam int unsigned WR_BIT        = 7;
  localparam int unsigned BUSY_RISE_CYC = 16;

  typedef logic [15:0] cnt_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } init_entry_t;

  // Register address byte as sent on the wire; a cleared WR_BIT marks a write.
  function automatic logic [7:0] wr_addr_byte(input logic [6:0] addr);
    logic [7:0] b;
    b         = '0;
    b[6:0]    = addr;
    b[WR_BIT] = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/radio_spi_scheduler_init_rom.sv
// Radio register init table: 4-bit index to {addr[6:0], data[7:0]}.
module radio_init_rom
  import radio_spi_scheduler_pkg::*;
(
  input  logic [3:0]  i_idx,
  output init_entry_t o_entry
);

  always_comb begin
    o_entry = '0;
    case (i_idx)
      4'd0:  o_entry = '{addr: 7'h01, data: 8'h80};
      4'd1:  o_entry = '{addr: 7'h02, data: 8'h1A};
      4'd2:  o_entry = '{addr: 7'h03, data: 8'h3C};
      4'd3:  o_entry = '{addr: 7'h04, data: 8'h55};
      4'd4:  o_entry = '{addr: 7'h05, data: 8'hA5};
      4'd5:  o_entry = '{addr: 7'h06, data: 8'h0F};
      4'd6:  o_entry = '{addr: 7'h08, data: 8'h42};
      4'd7:  o_entry = '{addr: 7'h09, data: 8'h7E};
      4'd8:  o_entry = '{addr: 7'h0A, data: 8'h00};
      4'd9:  o_entry = '{addr: 7'h0B, data: 8'h00};
      4'd10: o_entry = '{addr: 7'h0C, data: 8'h00};
      4'd11: o_entry = '{addr: 7'h0D, data: 8'h00};
      4'd12: o_entry = '{addr: 7'h0E, data: 8'h00};
      4'd13: o_entry = '{addr: 7'h0F, data: 8'h00};
      4'd14: o_entry = '{addr: 7'h10, data: 8'h00};
      4'd15: o_entry = '{addr: 7'h11, data: 8'h00};
      default: o_entry = '0;
    endcase
  end

endmodule

// File: rtl/radio_spi_scheduler.sv
// Shares the radio SPI byte engine between the config sequencer (init table,
// mode-register rewrites on push_to_talk changes) and packet_manager.
module radio_spi_scheduler
  import radio_spi_scheduler_pkg::*;
#(
  parameter int unsigned POR_WAIT_CYC  = 5000,
  parameter int unsigned INIT_LEN      = 8,
  parameter logic [7:0]  MODE_REG_ADDR = 8'h07,
  parameter logic [7:0]  TX_MODE_VAL   = 8'h09,
  parameter logic [7:0]  RX_MODE_VAL   = 8'h05,
  parameter int unsigned CS_GUARD_CYC  = 4,
  parameter int unsigned GAP_CYC       = 32,
  parameter int unsigned BUSY_TMO_CYC  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_to_talk,
  input  logic       pm_tx_start,
  input  logic [7:0] pm_tx_data,
  output logic       pm_tx_busy,
  output logic       spi_tx_start,
  output logic [7:0] spi_tx_data,
  input  logic       spi_tx_busy,
  output logic       spi_master_mode,
  output logic       radio_cs_n,
  output logic       pm_grant,
  output logic       cfg_done,
  output logic       cfg_error
);

  state_t      r_state, w_state_nxt;
  cnt_t        r_cnt, w_cnt_nxt;
  cnt_t        r_gap, w_gap_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_seen, w_seen_nxt;
  logic        r_mode_wr, w_mode_wr_nxt;
  logic        r_mode_pend, w_mode_pend_nxt;
  logic        r_pm_cs, w_pm_cs_nxt;
  logic        r_cfg_done, w_cfg_done_nxt;
  logic        r_cfg_error, w_cfg_error_nxt;
  logic        r_ptt_s1, r_ptt_s2, r_ptt_d;
  logic        w_ptt_edge, w_pm_idle, w_abort;
  init_entry_t w_rom;

  radio_init_rom u_rom (
    .i_idx   (r_idx),
    .o_entry (w_rom)
  );

  assign w_ptt_edge = r_ptt_s2 ^ r_ptt_d;
  assign cfg_done   = r_cfg_done;
  assign cfg_error  = r_cfg_error;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + cnt_t'(1);
    w_gap_nxt       = '0;
    w_idx_nxt       = r_idx;
    w_seen_nxt      = r_seen;
    w_mode_wr_nxt   = r_mode_wr;
    w_mode_pend_nxt = r_mode_pend | w_ptt_edge;
    w_pm_cs_nxt     = 1'b0;
    w_cfg_done_nxt  = r_cfg_done;
    w_cfg_error_nxt = r_cfg_error;
    w_pm_idle       = 1'b0;
    w_abort         = 1'b0;
    spi_tx_start    = 1'b0;
    spi_tx_data     = '0;
    radio_cs_n      = 1'b0;
    pm_grant        = 1'b0;
    pm_tx_busy      = 1'b1;
    spi_master_mode = 1'b1;
    case (r_state)
      ST_POR_WAIT: begin
        radio_cs_n = 1'b1;
        if (r_cnt >= cnt_t'(POR_WAIT_CYC - 1)) begin
          w_state_nxt = ST_CS_SETUP;
          w_cnt_nxt   = '0;
        end
      end
      ST_CS_SETUP: begin
        if (r_cnt >= cnt_t'(CS_GUARD_CYC - 1)) begin
          w_state_nxt = ST_SEND_ADDR;
          w_cnt_nxt   = '0;
        end
      end
      ST_SEND_ADDR, ST_SEND_DATA: begin
        // Counter starts at 1 so the wait state sees cycles elapsed since the start pulse.
        w_cnt_nxt  = cnt_t'(1);
        w_seen_nxt = 1'b0;
        if (!spi_tx_busy) begin
          spi_tx_start = 1'b1;
          if (r_state == ST_SEND_ADDR) begin
            spi_tx_data = wr_addr_byte(r_mode_wr ? MODE_REG_ADDR[6:0] : w_rom.addr);
            w_state_nxt = ST_WAIT_ADDR;
          end else begin
            spi_tx_data = r_mode_wr ? (r_ptt_s2 ? TX_MODE_VAL : RX_MODE_VAL) : w_rom.data;
            if (r_mode_wr) w_mode_pend_nxt = 1'b0;
            w_state_nxt = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_ADDR, ST_WAIT_DATA: begin
        if (!r_seen) begin
          if (spi_tx_busy) begin
            w_seen_nxt = 1'b1;
            w_cnt_nxt  = '0;
          end else if (r_cnt >= cnt_t'(BUSY_RISE_CYC - 1)) begin
            w_abort = 1'b1;
          end
        end else if (!spi_tx_busy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_state == ST_WAIT_ADDR) ? ST_SEND_DATA : ST_CS_HOLD;
        end else if (r_cnt >= cnt_t'(BUSY_TMO_CYC - 1)) begin
          w_abort = 1'b1;
        end
      end
      ST_CS_HOLD: begin
        if (r_cnt >= cnt_t'(CS_GUARD_CYC - 1)) begin
          w_state_nxt = ST_NEXT;
          w_cnt_nxt   = '0;
        end
      end
      ST_NEXT: begin
        radio_cs_n = 1'b1;
        w_cnt_nxt  = '0;
        if (r_mode_wr) begin
          w_mode_wr_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (r_idx >= 4'(INIT_LEN - 1)) begin
          w_idx_nxt       = '0;
          w_cfg_done_nxt  = 1'b1;
          w_mode_pend_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_idx_nxt   = r_idx + 4'd1;
          w_state_nxt = ST_CS_SETUP;
        end
      end
      ST_RECOVER: begin
        radio_cs_n  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_CS_SETUP;
      end
      ST_IDLE: begin
        pm_grant        = 1'b1;
        spi_tx_start    = pm_tx_start;
        spi_tx_data     = pm_tx_data;
        pm_tx_busy      = spi_tx_busy;
        spi_master_mode = r_ptt_s2;
        radio_cs_n      = ~(pm_tx_start | r_pm_cs);
        w_pm_idle       = ~pm_tx_start & ~spi_tx_busy;
        if (w_pm_idle)
          w_gap_nxt = (r_gap >= cnt_t'(GAP_CYC)) ? r_gap : r_gap + cnt_t'(1);
        w_pm_cs_nxt = pm_tx_start | (r_pm_cs & (w_gap_nxt < cnt_t'(GAP_CYC)));
        if (r_mode_pend && w_pm_idle && r_gap >= cnt_t'(GAP_CYC)) begin
          w_state_nxt   = ST_CS_SETUP;
          w_mode_wr_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_gap_nxt     = '0;
          w_pm_cs_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_POR_WAIT;
    endcase
    if (w_abort) begin
      w_cfg_error_nxt = 1'b1;
      w_idx_nxt       = '0;
      w_mode_wr_nxt   = 1'b0;
      w_cnt_nxt       = '0;
      w_state_nxt     = ST_RECOVER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_POR_WAIT;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_idx       <= '0;
      r_seen      <= 1'b0;
      r_mode_wr   <= 1'b0;
      r_mode_pend <= 1'b0;
      r_pm_cs     <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_cfg_error <= 1'b0;
      r_ptt_s1    <= 1'b0;
      r_ptt_s2    <= 1'b0;
      r_ptt_d     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_idx       <= w_idx_nxt;
      r_seen      <= w_seen_nxt;
      r_mode_wr   <= w_mode_wr_nxt;
      r_mode_pend <= w_mode_pend_nxt;
      r_pm_cs     <= w_pm_cs_nxt;
      r_cfg_done  <= w_cfg_done_nxt;
      r_cfg_error <= w_cfg_error_nxt;
      r_ptt_s1    <= push_to_talk;
      r_ptt_s2    <= r_ptt_s1;
      r_ptt_d     <= r_ptt_s2;
    end
  end

endmodule

// File: tb/tb_radio_spi_scheduler.sv
// Scoreboard bench: stimulus queues expected SPI frames/bytes, a negedge monitor
// reassembles cs_n frames and compares; a transceiver model drives spi_tx_busy.
`timescale 1ns/1ps
module tb_radio_spi_scheduler;

  localparam int POR = 200;

  logic       clk = 1'b0;
  logic       rst, push_to_talk, pm_tx_start, spi_tx_busy;
  logic [7:0] pm_tx_data;
  logic       pm_tx_busy, spi_tx_start, spi_master_mode, radio_cs_n, pm_grant, cfg_done, cfg_error;
  logic [7:0] spi_tx_data;

  always #10 clk = ~clk;

  radio_spi_scheduler #(.POR_WAIT_CYC(POR)) dut (
    .clk(clk), .rst(rst), .push_to_talk(push_to_talk),
    .pm_tx_start(pm_tx_start), .pm_tx_data(pm_tx_data), .pm_tx_busy(pm_tx_busy),
    .spi_tx_start(spi_tx_start), .spi_tx_data(spi_tx_data), .spi_tx_busy(spi_tx_busy),
    .spi_master_mode(spi_master_mode), .radio_cs_n(radio_cs_n), .pm_grant(pm_grant),
    .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  typedef struct { logic [7:0] a; logic [7:0] d; int n; } frame_t;

  frame_t     exp_q[$];
  logic [7:0] pm_q[$];
  logic [7:0] got[$];
  frame_t     m_e;
  logic       m_prev_cs = 1'b1;
  int         n_vec = 0, n_err = 0, sched_bytes = 0, tgt = 0, m_cnt = 0;
  bit         fault_armed = 1'b0;
  logic [7:0] tbl_a [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09};
  logic [7:0] tbl_d [8] = '{8'h80, 8'h1A, 8'h3C, 8'h55, 8'hA5, 8'h0F, 8'h42, 8'h7E};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return cfg_done === 1'b1;
      1: return exp_q.size() == 0 && pm_grant === 1'b1;
      2: return cfg_error === 1'b1;
      3: return !fault_armed;
      4: return pm_tx_busy === 1'b0;
      5: return sched_bytes >= tgt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string nm, output int took);
    took = 0;
    while (!cond(sel)) begin
      if (took >= budget) begin
        n_vec++; n_err++;
        $display("FAIL %s: condition not reached within %0d cycles", nm, budget);
        return;
      end
      cyc(1);
      took++;
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 8; i++) exp_q.push_back('{tbl_a[i], tbl_d[i], 2});
  endtask

  task automatic pm_send(input logic [7:0] b);
    pm_q.push_back(b);
    pm_tx_data  = b;
    pm_tx_start = 1'b1;
    #1;
    chk("pm_start_passthru", spi_tx_start, 1);
    chk("pm_data_passthru", spi_tx_data, b);
    chk("pm_cs_asserted", radio_cs_n, 0);
    chk("pm_granted", pm_grant, 1);
    cyc(1);
    pm_tx_start = 1'b0;
  endtask

  // spi_transceiver model: busy rises 2 cycles after a start and lasts 20 cycles.
  initial begin
    logic s, g;
    logic [7:0] d;
    spi_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      s = spi_tx_start; g = pm_grant; d = spi_tx_data;
      #1;
      if (m_cnt > 0) begin
        m_cnt++;
        if (m_cnt == 3) spi_tx_busy = 1'b1;
        if (m_cnt == 23) begin spi_tx_busy = 1'b0; m_cnt = 0; end
      end
      if (s === 1'b1) begin
        if (fault_armed && !g && d == tbl_a[3]) fault_armed = 1'b0;
        else m_cnt = 1;
      end
    end
  end

  // Monitor: collects scheduler bytes per cs_n frame, checks pm bytes immediately.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        got.delete();
        m_prev_cs = 1'b1;
      end else begin
        if (!pm_grant) begin
          chk("pm_busy_forced", pm_tx_busy, 1);
          chk("master_forced", spi_master_mode, 1);
        end
        if (spi_tx_start === 1'b1) begin
          if (pm_grant) begin
            if (pm_q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL pm_byte: got unexpected byte %02h, expected none", spi_tx_data);
            end else chk("pm_byte", spi_tx_data, pm_q.pop_front());
          end else begin
            got.push_back(spi_tx_data);
            sched_bytes++;
          end
        end
        if (!m_prev_cs && radio_cs_n && got.size() > 0) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL frame_unexpected: got %0d bytes starting %02h, expected none", got.size(), got[0]);
          end else begin
            m_e = exp_q.pop_front();
            chk("frame_len", got.size(), m_e.n);
            chk("frame_addr", got[0], m_e.a);
            if (m_e.n == 2 && got.size() >= 2) chk("frame_data", got[1], m_e.d);
          end
          got.delete();
        end
        m_prev_cs = radio_cs_n;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int took, nb;
    logic [7:0] b;
    rst = 1'b1; push_to_talk = 1'b0; pm_tx_start = 1'b0; pm_tx_data = '0;
    cyc(4);
    chk("rst_spi_tx_start", spi_tx_start, 0);
    chk("rst_spi_tx_data", spi_tx_data, 0);
    chk("rst_cs_n", radio_cs_n, 1);
    chk("rst_pm_grant", pm_grant, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_error", cfg_error, 0);
    chk("rst_master_mode", spi_master_mode, 1);
    chk("rst_pm_busy", pm_tx_busy, 1);

    // Init table after power-on wait.
    push_init();
    rst = 1'b0;
    wait_for(0, POR + 8 * 80, "init_done", took);
    chk("init_frames_seen", exp_q.size(), 0);
    chk("init_no_error", cfg_error, 0);

    // pm byte right after init, then the post-init mode write (ptt=0).
    pm_send(8'hCA);
    cyc(2);
    chk("pm_busy_follows_hi", pm_tx_busy, 1);
    chk("pm_cs_held_busy", radio_cs_n, 0);
    wait_for(4, 40, "pm_busy_fall", took);
    chk("pm_cs_held_gap", radio_cs_n, 0);
    chk("idle_master_ptt0", spi_master_mode, 0);
    exp_q.push_back('{8'h07, 8'h05, 2});
    wait_for(1, 400, "post_init_mode_frame", took);

    // ptt 0->1 during a pm stream: no preemption until the stream stops.
    nb = 5 + int'($urandom_range(0, 3));
    b = 8'($urandom);
    pm_send(b);
    push_to_talk = 1'b1;
    for (int i = 1; i < nb; i++) begin
      cyc(3);
      wait_for(4, 40, "stream_busy_fall", took);
      cyc(10 + int'($urandom_range(0, 5)));
      b = 8'($urandom);
      pm_send(b);
    end
    cyc(6);
    chk("idle_master_ptt1", spi_master_mode, 1);
    tgt = sched_bytes + 2;
    exp_q.push_back('{8'h07, 8'h09, 2});
    wait_for(5, 300, "tx_mode_data_sent", took);
    // ptt falls after the data byte went out: a second frame follows.
    push_to_talk = 1'b0;
    exp_q.push_back('{8'h07, 8'h05, 2});
    wait_for(1, 400, "mode_frames_done", took);
    chk("pm_queue_drained", pm_q.size(), 0);

    // Transfer timeout on init entry 3, then a clean restart.
    rst = 1'b1;
    cyc(3);
    fault_armed = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{tbl_a[i], tbl_d[i], 2});
    exp_q.push_back('{tbl_a[3], 8'h00, 1});
    push_init();
    exp_q.push_back('{8'h07, 8'h05, 2});
    rst = 1'b0;
    wait_for(3, POR + 400, "fault_entry_reached", took);
    wait_for(2, 16, "cfg_error_rise", took);
    chk("err_cs_released", radio_cs_n, 1);
    chk("err_not_done", cfg_done, 0);
    wait_for(0, 8 * 80 + 100, "reinit_done", took);
    chk("reinit_frames_left", exp_q.size(), 1);
    chk("err_sticky", cfg_error, 1);
    wait_for(1, 400, "reinit_mode_frame", took);

    // Reset mid-frame during a mode write.
    push_to_talk = 1'b1;
    exp_q.push_back('{8'h07, 8'h09, 2});
    tgt = sched_bytes + 1;
    wait_for(5, 200, "frame_started", took);
    chk("pre_rst_done", cfg_done, 1);
    chk("pre_rst_cs_low", radio_cs_n, 0);
    rst = 1'b1;
    cyc(1);
    chk("midrst_cs_n", radio_cs_n, 1);
    chk("midrst_spi_start", spi_tx_start, 0);
    chk("midrst_grant", pm_grant, 0);
    chk("midrst_cfg_done", cfg_done, 0);
    chk("midrst_cfg_error", cfg_error, 0);
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chk("post_rst_cs_n", radio_cs_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
